// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the CDB arbiter: default sizes and producer port indices.
package cdb_arbiter_pkg;

  localparam int CDB_NREQ     = 4;
  localparam int ROB_BITS_DEF = 4;

  typedef enum logic [2:0] {
    CDB_ALU   = 3'd0,
    CDB_LSB   = 3'd1,
    CDB_BR    = 3'd2,
    CDB_SPARE = 3'd3
  } cdb_src_e;

endpackage

// File: rtl/cdb_arbiter_rr_pick2.sv
// Round-robin picker: starting at rr_ptr, returns the first two valid requesters.
module cdb_arbiter_rr_pick2 #(
  parameter int NREQ     = 4,
  parameter int PTR_BITS = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]     req_valid,
  input  logic [PTR_BITS-1:0] rr_ptr,
  output logic [PTR_BITS-1:0] g0,
  output logic [PTR_BITS-1:0] g1,
  output logic                g0_vld,
  output logic                g1_vld
);

  int                  idx;
  logic [PTR_BITS-1:0] idx_p;

  always_comb begin
    g0     = '0;
    g1     = '0;
    g0_vld = 1'b0;
    g1_vld = 1'b0;
    idx    = 0;
    idx_p  = '0;
    for (int i = 0; i < NREQ; i++) begin
      // wrap the scan index without a modulo operator
      idx = int'(rr_ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      idx_p = PTR_BITS'(idx);
      if (req_valid[idx_p]) begin
        if (!g0_vld) begin
          g0     = idx_p;
          g0_vld = 1'b1;
        end else if (!g1_vld) begin
          g1     = idx_p;
          g1_vld = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Two-channel common data bus arbiter with round-robin grant and registered broadcast.
// Optional per-producer perf counters are built when CDB_PERF_EN is defined.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NREQ     = CDB_NREQ,
  parameter int ROB_BITS = ROB_BITS_DEF,
  parameter int PTR_BITS = $clog2(NREQ)
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     clear,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*ROB_BITS-1:0] req_id,
  input  logic [NREQ*32-1:0]       req_value,
  output logic [NREQ-1:0]          req_ready,
  output logic                     cdb1_rdy,
  output logic [ROB_BITS-1:0]      cdb1_id,
  output logic [31:0]              cdb1_value,
  output logic                     cdb2_rdy,
  output logic [ROB_BITS-1:0]      cdb2_id,
  output logic [31:0]              cdb2_value
`ifdef CDB_PERF_EN
  ,
  output logic [NREQ*32-1:0]       perf_grant_cnt,
  output logic [NREQ*32-1:0]       perf_stall_cnt
`endif
);

  logic [PTR_BITS-1:0] rr_ptr;
  logic [PTR_BITS-1:0] g0, g1;
  logic                g0_vld, g1_vld;
  logic                active;
  logic [ROB_BITS-1:0] id_arr  [NREQ];
  logic [31:0]         val_arr [NREQ];

  function automatic logic [PTR_BITS-1:0] ptr_next(input logic [PTR_BITS-1:0] p);
    if (int'(p) == NREQ - 1) return '0;
    return p + PTR_BITS'(1);
  endfunction

  cdb_arbiter_rr_pick2 #(
    .NREQ     (NREQ),
    .PTR_BITS (PTR_BITS)
  ) u_pick (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .g0        (g0),
    .g1        (g1),
    .g0_vld    (g0_vld),
    .g1_vld    (g1_vld)
  );

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      id_arr[i]  = req_id[i*ROB_BITS +: ROB_BITS];
      val_arr[i] = req_value[i*32 +: 32];
    end
  end

  // Grants are suppressed asynchronously during reset, and by pause or flush.
  assign active = rst_in && rdy_in && !clear;

  always_comb begin
    req_ready = '0;
    if (active) begin
      if (g0_vld) req_ready[g0] = 1'b1;
      if (g1_vld) req_ready[g1] = 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cdb1_rdy   <= 1'b0;
      cdb1_id    <= '0;
      cdb1_value <= '0;
      cdb2_rdy   <= 1'b0;
      cdb2_id    <= '0;
      cdb2_value <= '0;
      rr_ptr     <= '0;
    end else if (clear) begin
      // flush wins over pause; pointer and last id/value are kept
      cdb1_rdy <= 1'b0;
      cdb2_rdy <= 1'b0;
    end else if (rdy_in) begin
      cdb1_rdy <= g0_vld;
      cdb2_rdy <= g1_vld;
      if (g0_vld) begin
        cdb1_id    <= id_arr[g0];
        cdb1_value <= val_arr[g0];
      end
      if (g1_vld) begin
        cdb2_id    <= id_arr[g1];
        cdb2_value <= val_arr[g1];
      end
      if (g1_vld)      rr_ptr <= ptr_next(g1);
      else if (g0_vld) rr_ptr <= ptr_next(g0);
    end
  end

`ifdef CDB_PERF_EN
  logic [31:0] grant_cnt [NREQ];
  logic [31:0] stall_cnt [NREQ];

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < NREQ; i++) begin
        grant_cnt[i] <= '0;
        stall_cnt[i] <= '0;
      end
    end else if (active) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i])  grant_cnt[i] <= grant_cnt[i] + 32'd1;
        if (req_valid[i] && !req_ready[i]) stall_cnt[i] <= stall_cnt[i] + 32'd1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      perf_grant_cnt[i*32 +: 32] = grant_cnt[i];
      perf_stall_cnt[i*32 +: 32] = stall_cnt[i];
    end
  end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter (NREQ=4, ROB_BITS=4).
module tb_cdb_arbiter;

  localparam int NREQ     = 4;
  localparam int ROB_BITS = 4;

  logic                     clk_in;
  logic                     rst_in;
  logic                     rdy_in;
  logic                     clear;
  logic [NREQ-1:0]          req_valid;
  logic [NREQ*ROB_BITS-1:0] req_id;
  logic [NREQ*32-1:0]       req_value;
  logic [NREQ-1:0]          req_ready;
  logic                     cdb1_rdy;
  logic [ROB_BITS-1:0]      cdb1_id;
  logic [31:0]              cdb1_value;
  logic                     cdb2_rdy;
  logic [ROB_BITS-1:0]      cdb2_id;
  logic [31:0]              cdb2_value;
`ifdef CDB_PERF_EN
  logic [NREQ*32-1:0]       perf_grant_cnt;
  logic [NREQ*32-1:0]       perf_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  cdb_arbiter #(
    .NREQ     (NREQ),
    .ROB_BITS (ROB_BITS)
  ) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .rdy_in     (rdy_in),
    .clear      (clear),
    .req_valid  (req_valid),
    .req_id     (req_id),
    .req_value  (req_value),
    .req_ready  (req_ready),
    .cdb1_rdy   (cdb1_rdy),
    .cdb1_id    (cdb1_id),
    .cdb1_value (cdb1_value),
    .cdb2_rdy   (cdb2_rdy),
    .cdb2_id    (cdb2_id),
    .cdb2_value (cdb2_value)
`ifdef CDB_PERF_EN
    ,
    .perf_grant_cnt (perf_grant_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  // Broadcast triple packed as {rdy, id, value}
  function automatic logic [63:0] b1();
    return {27'd0, cdb1_rdy, cdb1_id, cdb1_value};
  endfunction
  function automatic logic [63:0] b2();
    return {27'd0, cdb2_rdy, cdb2_id, cdb2_value};
  endfunction
  function automatic logic [63:0] exp_b(input logic r, input logic [3:0] id, input logic [31:0] v);
    return {27'd0, r, id, v};
  endfunction

  initial begin
    rst_in    = 1'b0;
    rdy_in    = 1'b1;
    clear     = 1'b0;
    req_valid = 4'b1111;
    req_id    = 16'h4321;
    req_value = {32'h103, 32'h102, 32'h101, 32'h100};
    #2;
    chk("reset_ready", 64'(req_ready), 64'h0);
    chk("reset_cdb1", b1(), exp_b(1'b0, 4'd0, 32'd0));
    chk("reset_cdb2", b2(), exp_b(1'b0, 4'd0, 32'd0));
    req_valid = 4'b0000;
    @(negedge clk_in);
    rst_in = 1'b1;
    cyc();

    // Single request from producer 2
    req_valid = 4'b0100;
    req_id    = 16'h4521;
    req_value = {32'h103, 32'hDEAD, 32'h101, 32'h100};
    #1;
    chk("single_ready", 64'(req_ready), 64'(4'b0100));
    cyc();
    chk("single_cdb1", b1(), exp_b(1'b1, 4'd5, 32'hDEAD));
    chk("single_cdb2_rdy", 64'(cdb2_rdy), 64'h0);
    req_valid = 4'b0000;
    req_id    = 16'h4321;
    req_value = {32'h103, 32'h102, 32'h101, 32'h100};
    #1;
    chk("idle_ready", 64'(req_ready), 64'h0);
    cyc();
    chk("idle_cdb1_hold", b1(), exp_b(1'b0, 4'd5, 32'hDEAD));

    // Pointer now 3: a lone request from 3 brings it back to 0
    req_valid = 4'b1000;
    #1;
    chk("wrap_ready", 64'(req_ready), 64'(4'b1000));
    cyc();
    chk("wrap_cdb1", b1(), exp_b(1'b1, 4'd4, 32'h103));

    // Dual grants with all four valid
    req_valid = 4'b1111;
    #1;
    chk("dual1_ready", 64'(req_ready), 64'(4'b0011));
    cyc();
    chk("dual1_cdb1", b1(), exp_b(1'b1, 4'd1, 32'h100));
    chk("dual1_cdb2", b2(), exp_b(1'b1, 4'd2, 32'h101));
    chk("dual2_ready", 64'(req_ready), 64'(4'b1100));
    cyc();
    chk("dual2_cdb1", b1(), exp_b(1'b1, 4'd3, 32'h102));
    chk("dual2_cdb2", b2(), exp_b(1'b1, 4'd4, 32'h103));
    chk("dual3_ready", 64'(req_ready), 64'(4'b0011));
    cyc();
    chk("dual3_cdb1", b1(), exp_b(1'b1, 4'd1, 32'h100));
    chk("dual3_cdb2", b2(), exp_b(1'b1, 4'd2, 32'h101));

    // Asynchronous reset in the middle of a broadcast
    rst_in = 1'b0;
    #1;
    chk("midrst_ready", 64'(req_ready), 64'h0);
    chk("midrst_cdb1_rdy", 64'(cdb1_rdy), 64'h0);
    chk("midrst_cdb2_rdy", 64'(cdb2_rdy), 64'h0);
    req_valid = 4'b0000;
    @(negedge clk_in);
    rst_in = 1'b1;
    cyc();

    // Contention with 1011 held, pointer restarted at 0
    req_valid = 4'b1011;
    #1;
    chk("cont1_ready", 64'(req_ready), 64'(4'b0011));
    cyc();
    chk("cont1_cdb1", b1(), exp_b(1'b1, 4'd1, 32'h100));
    chk("cont1_cdb2", b2(), exp_b(1'b1, 4'd2, 32'h101));
    chk("cont2_ready", 64'(req_ready), 64'(4'b1001));
    cyc();
    chk("cont2_cdb1", b1(), exp_b(1'b1, 4'd4, 32'h103));
    chk("cont2_cdb2", b2(), exp_b(1'b1, 4'd1, 32'h100));
    chk("cont3_ready", 64'(req_ready), 64'(4'b1010));
    cyc();
    chk("cont3_cdb1", b1(), exp_b(1'b1, 4'd2, 32'h101));
    chk("cont3_cdb2", b2(), exp_b(1'b1, 4'd4, 32'h103));

    // Pause right after a grant: broadcast persists, no grants
    rdy_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("pause_ready", 64'(req_ready), 64'h0);
      cyc();
      chk("pause_cdb1", b1(), exp_b(1'b1, 4'd2, 32'h101));
      chk("pause_cdb2", b2(), exp_b(1'b1, 4'd4, 32'h103));
    end
    rdy_in    = 1'b1;
    req_valid = 4'b0010;
    #1;
    chk("resume_ready", 64'(req_ready), 64'(4'b0010));
    cyc();
    chk("resume_cdb1", b1(), exp_b(1'b1, 4'd2, 32'h101));
    chk("resume_cdb2_rdy", 64'(cdb2_rdy), 64'h0);

    // Flush with pointer at 2: drops broadcast, pointer kept
    req_valid = 4'b1111;
    clear     = 1'b1;
    #1;
    chk("flush_ready", 64'(req_ready), 64'h0);
    cyc();
    chk("flush_cdb1_rdy", 64'(cdb1_rdy), 64'h0);
    chk("flush_cdb2_rdy", 64'(cdb2_rdy), 64'h0);
    clear = 1'b0;
    #1;
    chk("postflush_ready", 64'(req_ready), 64'(4'b1100));
    cyc();
    chk("postflush_cdb1", b1(), exp_b(1'b1, 4'd3, 32'h102));
    chk("postflush_cdb2", b2(), exp_b(1'b1, 4'd4, 32'h103));

    // Flush during pause still clears the pending broadcast
    req_valid = 4'b0001;
    #1;
    chk("pre_pf_ready", 64'(req_ready), 64'(4'b0001));
    cyc();
    chk("pre_pf_cdb1", b1(), exp_b(1'b1, 4'd1, 32'h100));
    req_valid = 4'b1111;
    rdy_in    = 1'b0;
    clear     = 1'b1;
    #1;
    chk("pf_ready", 64'(req_ready), 64'h0);
    cyc();
    chk("pf_cdb1_rdy", 64'(cdb1_rdy), 64'h0);
    chk("pf_cdb2_rdy", 64'(cdb2_rdy), 64'h0);
    rdy_in = 1'b1;
    clear  = 1'b0;
    #1;
    chk("post_pf_ready", 64'(req_ready), 64'(4'b0110));
    cyc();
    chk("post_pf_cdb1", b1(), exp_b(1'b1, 4'd2, 32'h101));
    chk("post_pf_cdb2", b2(), exp_b(1'b1, 4'd3, 32'h102));
    req_valid = 4'b0000;
    cyc();
    chk("final_idle_cdb1_rdy", 64'(cdb1_rdy), 64'h0);
    chk("final_idle_cdb2_rdy", 64'(cdb2_rdy), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
